// File: rtl/dma_engine_if.sv
// Bus bundle between simt_group, the scratchpad port and the DRAM port of
// dma_engine. The engine uses the master view; the surrounding system (or a
// bench) uses the slave view.
interface dma_engine_if #(
    parameter int SRAM_AW = 14,
    parameter int DRAM_AW = 32
);
    // command side (from simt_group)
    logic [1:0]         dmaCmd;
    logic [31:0]        dmaSrcAddress;
    logic [31:0]        dmaDstAddress;
    logic [9:0]         dmaWidth;
    logic               dmaStall;
    logic               dmaDone;
    logic               dmaErr;

    // scratchpad port
    logic [SRAM_AW-1:0] sramAddr;
    logic               sramWe;
    logic [31:0]        sramWd;
    logic [31:0]        sramRd;

    // DRAM single-outstanding request port
    logic               dramReq;
    logic               dramWe;
    logic [DRAM_AW-1:0] dramAddr;
    logic [31:0]        dramWd;
    logic               dramAck;
    logic [31:0]        dramRd;

    modport master (
        input  dmaCmd, dmaSrcAddress, dmaDstAddress, dmaWidth,
        output dmaStall, dmaDone, dmaErr,
        output sramAddr, sramWe, sramWd,
        input  sramRd,
        output dramReq, dramWe, dramAddr, dramWd,
        input  dramAck, dramRd
    );

    modport slave (
        output dmaCmd, dmaSrcAddress, dmaDstAddress, dmaWidth,
        input  dmaStall, dmaDone, dmaErr,
        input  sramAddr, sramWe, sramWd,
        output sramRd,
        input  dramReq, dramWe, dramAddr, dramWd,
        output dramAck, dramRd
    );
endinterface

// File: rtl/dma_engine.sv
// dma_engine: moves blocks of 32-bit words between DRAM and the scratchpad
// SRAM, one word at a time, while holding the issuing SIMT group stalled.
// d2s costs 2 cycles/word and s2d 3 cycles/word with a zero-wait DRAM ack.
// Optional feature macro: DMA_ALIGN_CHECK_EN -- rejects misaligned byte
// addresses and SRAM ranges running past the top of the scratchpad, reporting
// dmaErr with the dmaDone pulse. Without it, dmaErr is tied low and SRAM word
// addresses simply wrap.
module dma_engine #(
    parameter int SRAM_AW = 14,
    parameter int DRAM_AW = 32
) (
    input logic          clk,
    input logic          reset,
    dma_engine_if.master bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        D2S_REQ = 3'd1,
        D2S_WR  = 3'd2,
        S2D_RD  = 3'd3,
        S2D_CAP = 3'd4,
        S2D_REQ = 3'd5,
        DONE    = 3'd6
    } state_t;

    state_t      state;
    state_t      state_next;

    // parameters latched at accept; later input changes are ignored
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [9:0]  width;
    // index of the word currently in flight
    logic [9:0]  n;
    // word in transit between the two memories
    logic [31:0] word;

    logic        cmd_valid;
    logic        accept;
    logic        last;
    logic        err_now;

    // SRAM word address of element idx of a block, wrapping at 2^SRAM_AW
    function automatic logic [SRAM_AW-1:0] sram_word(input logic [SRAM_AW-1:0] base,
                                                     input logic [9:0]         idx);
        return base + SRAM_AW'(idx);
    endfunction

    // DRAM byte address of element idx of a block, wrapping at 2^DRAM_AW
    function automatic logic [DRAM_AW-1:0] dram_byte(input logic [31:0] base,
                                                     input logic [9:0]  idx);
        return DRAM_AW'(base + {20'd0, idx, 2'b00});
    endfunction

    // only the two transfer opcodes start work; 11 is ignored like 00
    assign cmd_valid = (bus.dmaCmd == 2'b01) || (bus.dmaCmd == 2'b10);
    assign accept    = (state == IDLE) && cmd_valid;
    assign last      = ((n + 10'd1) == width);

`ifdef DMA_ALIGN_CHECK_EN
    localparam logic [SRAM_AW+10:0] SRAM_WORDS = (SRAM_AW+11)'(1) << SRAM_AW;

    logic [SRAM_AW-1:0]  side_word;
    logic [SRAM_AW+10:0] range_end;
    logic                err;

    // the SRAM side is the destination for d2s and the source for s2d
    assign side_word = (bus.dmaCmd == 2'b01) ? bus.dmaDstAddress[SRAM_AW+1:2]
                                             : bus.dmaSrcAddress[SRAM_AW+1:2];
    // one past the last SRAM word touched; wide enough not to wrap
    assign range_end = (SRAM_AW+11)'(side_word) + (SRAM_AW+11)'(bus.dmaWidth);
    assign err_now   = (bus.dmaSrcAddress[1:0] != 2'b00) ||
                       (bus.dmaDstAddress[1:0] != 2'b00) ||
                       (range_end > SRAM_WORDS);

    // remember whether the accepted command was rejected, for the DONE cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            err <= 1'b0;
        end else if (accept) begin
            err <= err_now;
        end
    end
`else
    assign err_now = 1'b0;
`endif

    // state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // next-state selection
    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (err_now || (bus.dmaWidth == 10'd0)) begin
                        state_next = DONE;
                    end else if (bus.dmaCmd == 2'b01) begin
                        state_next = D2S_REQ;
                    end else begin
                        state_next = S2D_RD;
                    end
                end
            end
            D2S_REQ: begin
                if (bus.dramAck) begin
                    state_next = D2S_WR;
                end
            end
            D2S_WR: begin
                state_next = last ? DONE : D2S_REQ;
            end
            S2D_RD: begin
                state_next = S2D_CAP;
            end
            S2D_CAP: begin
                state_next = S2D_REQ;
            end
            S2D_REQ: begin
                if (bus.dramAck) begin
                    state_next = last ? DONE : S2D_RD;
                end
            end
            DONE: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // latch the command at accept and advance the word index per transfer
    always_ff @(posedge clk) begin
        if (reset) begin
            src_addr <= 32'd0;
            dst_addr <= 32'd0;
            width    <= 10'd0;
            n        <= 10'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        src_addr <= bus.dmaSrcAddress;
                        dst_addr <= bus.dmaDstAddress;
                        width    <= bus.dmaWidth;
                        n        <= 10'd0;
                    end
                end
                D2S_WR: begin
                    n <= n + 10'd1;
                end
                S2D_REQ: begin
                    if (bus.dramAck) begin
                        n <= n + 10'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // capture the word in transit: DRAM read data on ack, SRAM read data one
    // cycle after its address was presented
    always_ff @(posedge clk) begin
        if ((state == D2S_REQ) && bus.dramAck) begin
            word <= bus.dramRd;
        end else if (state == S2D_CAP) begin
            word <= bus.sramRd;
        end
    end

    // drive the memory ports and status outputs from the current state;
    // request fields depend only on latched registers so they hold steady
    // for as long as dramReq waits for its ack
    always_comb begin
        bus.sramAddr = '0;
        bus.sramWe   = 1'b0;
        bus.sramWd   = 32'd0;
        bus.dramReq  = 1'b0;
        bus.dramWe   = 1'b0;
        bus.dramAddr = '0;
        bus.dramWd   = 32'd0;
        bus.dmaDone  = 1'b0;
        bus.dmaErr   = 1'b0;
        case (state)
            D2S_REQ: begin
                bus.dramReq  = 1'b1;
                bus.dramAddr = dram_byte(src_addr, n);
            end
            D2S_WR: begin
                bus.sramWe   = 1'b1;
                bus.sramAddr = sram_word(dst_addr[SRAM_AW+1:2], n);
                bus.sramWd   = word;
            end
            S2D_RD: begin
                bus.sramAddr = sram_word(src_addr[SRAM_AW+1:2], n);
            end
            S2D_REQ: begin
                bus.dramReq  = 1'b1;
                bus.dramWe   = 1'b1;
                bus.dramAddr = dram_byte(dst_addr, n);
                bus.dramWd   = word;
            end
            DONE: begin
                bus.dmaDone  = 1'b1;
`ifdef DMA_ALIGN_CHECK_EN
                bus.dmaErr   = err;
`endif
            end
            default: begin
            end
        endcase
        // stall in the very cycle a command appears, released on the done pulse
        bus.dmaStall = cmd_valid && (state != DONE);
    end

endmodule
